// File: rtl/seq_counter_if.sv
// seq_counter_if: control, status and count signals of seq_counter
interface seq_counter_if #(parameter int Width = 4);
  logic start_i, stop_i, ena_i, up_i, oneshot_i;
  logic [Width-1:0] max_i, cnt_o;
  logic tick_o, busy_o, done_o;
  modport master(
    output start_i, stop_i, ena_i, up_i, oneshot_i, max_i,
    input cnt_o, tick_o, busy_o, done_o
  );
  modport slave(
    input start_i, stop_i, ena_i, up_i, oneshot_i, max_i,
    output cnt_o, tick_o, busy_o, done_o
  );
endinterface

// File: rtl/seq_counter.sv
// seq_counter: start/stop sequencer counting up or down modulo a per-run latched N, one-shot or wrapping
module seq_counter #(parameter int Width = 4) (
  input logic clk_i,
  input logic rst_i,
  seq_counter_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [Width-1:0] One = 1;
  state_t r_state;
  logic [Width-1:0] r_cnt, r_max;
  logic r_up, r_os, r_done;
  logic [Width-1:0] w_last, w_term, w_first;
  logic w_hit;
  // M=0 gives w_last = all ones, so the full 2^Width range needs no special case
  always_comb begin
    w_last = r_max - One;
    w_term = r_up ? w_last : '0;
    w_first = r_up ? '0 : w_last;
    w_hit = r_cnt == w_term;
  end
  assign bus.cnt_o = r_cnt;
  assign bus.tick_o = (r_state == RUN) & bus.ena_i & w_hit;
  assign bus.busy_o = r_state == RUN;
  assign bus.done_o = r_done;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_max <= '0;
      r_up <= 1'b0;
      r_os <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.stop_i) begin
        r_state <= IDLE;
        r_cnt <= '0;
      end else if (r_state == IDLE) begin
        if (bus.start_i) begin
          r_state <= RUN;
          r_max <= bus.max_i;
          r_up <= bus.up_i;
          r_os <= bus.oneshot_i;
          r_cnt <= bus.up_i ? '0 : bus.max_i - One;
        end
      end else if (bus.ena_i) begin
        if (!w_hit) begin
          r_cnt <= r_up ? r_cnt + One : r_cnt - One;
        end else if (!r_os) begin
          r_cnt <= w_first;
        end else begin
          r_cnt <= '0;
          r_state <= IDLE;
          r_done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_seq_counter.sv
// tb_seq_counter: table vectors, hand sequences and random stimulus against a step-count reference model
module tb_seq_counter;
  logic clk_i, rst_i;
  seq_counter_if #(.Width(4)) b();
  seq_counter #(.Width(4)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(b));

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks = 0, errors = 0;

  // model: a run is a count k of enabled steps modulo n
  int m_busy = 0, m_k = 0, m_n = 16, m_up = 0, m_os = 0, m_done = 0;
  int c_rst, c_start, c_stop, c_ena, c_up, c_os, c_mx;

  typedef struct {
    int rst, start, stop, ena, up, os, mx, cnt, tick, busy, done;
  } vec_t;
  vec_t tv[19];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int e_cnt();
    return m_busy != 0 ? (m_up != 0 ? m_k : m_n - 1 - m_k) : 0;
  endfunction

  function automatic int e_tick();
    return (m_busy != 0 && c_ena != 0 && m_k == m_n - 1) ? 1 : 0;
  endfunction

  task automatic drive(input int rst, start, stop, ena, up, os, mx);
    c_rst = rst; c_start = start; c_stop = stop; c_ena = ena;
    c_up = up; c_os = os; c_mx = mx;
    rst_i = 1'(rst);
    b.start_i = 1'(start);
    b.stop_i = 1'(stop);
    b.ena_i = 1'(ena);
    b.up_i = 1'(up);
    b.oneshot_i = 1'(os);
    b.max_i = 4'(mx);
    #1;
  endtask

  task automatic adv();
    int nd;
    chk("m_cnt", int'(b.cnt_o), e_cnt());
    chk("m_tick", int'(b.tick_o), e_tick());
    chk("m_busy", int'(b.busy_o), m_busy);
    chk("m_done", int'(b.done_o), m_done);
    @(posedge clk_i);
    nd = 0;
    if (c_rst != 0) begin
      m_busy = 0; m_k = 0;
    end else if (c_stop != 0) begin
      m_busy = 0; m_k = 0;
    end else if (m_busy == 0) begin
      if (c_start != 0) begin
        m_busy = 1; m_k = 0; m_up = c_up; m_os = c_os;
        m_n = c_mx == 0 ? 16 : c_mx;
      end
    end else if (c_ena != 0) begin
      m_k++;
      if (m_k == m_n) begin
        m_k = 0;
        if (m_os != 0) begin
          m_busy = 0; nd = 1;
        end
      end
    end
    m_done = nd;
    #1;
  endtask

  task automatic step(input int rst, start, stop, ena, up, os, mx);
    drive(rst, start, stop, ena, up, os, mx);
    adv();
  endtask

  initial begin
    int n_en, seen;
    tv = '{
      '{1,0,0,0,0,0,0, 0,0,0,0},
      '{0,1,0,1,1,1,5, 0,0,0,0},
      '{0,0,0,1,0,0,0, 0,0,1,0},
      '{0,0,0,1,0,0,0, 1,0,1,0},
      '{0,0,0,1,0,0,0, 2,0,1,0},
      '{0,0,0,1,0,0,0, 3,0,1,0},
      '{0,0,0,1,0,0,0, 4,1,1,0},
      '{0,0,0,1,0,0,0, 0,0,0,1},
      '{0,0,0,0,0,0,0, 0,0,0,0},
      '{0,1,1,0,1,1,5, 0,0,0,0},
      '{0,0,0,0,0,0,0, 0,0,0,0},
      '{0,1,0,1,0,0,3, 0,0,0,0},
      '{0,0,0,1,0,0,0, 2,0,1,0},
      '{0,0,0,1,0,0,0, 1,0,1,0},
      '{0,0,0,1,0,0,0, 0,1,1,0},
      '{0,0,0,1,0,0,0, 2,0,1,0},
      '{0,0,1,1,0,0,0, 1,0,1,0},
      '{0,0,0,1,0,0,0, 0,0,0,0},
      '{0,0,0,1,0,0,0, 0,0,0,0}
    };
    drive(1, 0, 0, 0, 0, 0, 0);
    @(posedge clk_i);
    #1;
    for (int i = 0; i < 19; i++) begin
      drive(tv[i].rst, tv[i].start, tv[i].stop, tv[i].ena, tv[i].up, tv[i].os, tv[i].mx);
      chk($sformatf("tv%0d_cnt", i), int'(b.cnt_o), tv[i].cnt);
      chk($sformatf("tv%0d_tick", i), int'(b.tick_o), tv[i].tick);
      chk($sformatf("tv%0d_busy", i), int'(b.busy_o), tv[i].busy);
      chk($sformatf("tv%0d_done", i), int'(b.done_o), tv[i].done);
      adv();
    end
    // full-range one-shot with enable gaps: exactly 16 enabled steps
    step(0, 1, 0, 1, 1, 1, 0);
    n_en = 0;
    seen = 0;
    for (int i = 0; i < 100 && seen == 0; i++) begin
      drive(0, 0, 0, (i % 3 == 1) ? 0 : 1, 0, 0, 7);
      if (b.done_o) seen = 1;
      else begin
        if (b.busy_o && c_ena != 0) n_en++;
        adv();
      end
    end
    chk("m0_done_seen", seen, 1);
    chk("m0_enabled_steps", n_en, 16);
    adv();
    // M=1 one-shot, then back-to-back start in the done cycle
    step(0, 1, 0, 0, 1, 1, 1);
    step(0, 0, 0, 1, 1, 1, 1);
    drive(0, 1, 0, 1, 1, 1, 2);
    chk("b2b_done", int'(b.done_o), 1);
    adv();
    drive(0, 0, 0, 1, 0, 0, 0);
    chk("b2b_busy", int'(b.busy_o), 1);
    chk("b2b_cnt0", int'(b.cnt_o), 0);
    adv();
    drive(0, 0, 0, 1, 0, 0, 0);
    chk("b2b_cnt1", int'(b.cnt_o), 1);
    adv();
    step(0, 0, 0, 0, 0, 0, 0);
    // mid-run input changes are ignored; reset at cnt=3 of an 8-step run
    step(0, 1, 0, 1, 1, 1, 8);
    step(0, 1, 0, 1, 0, 0, 3);
    step(0, 1, 0, 1, 0, 0, 3);
    step(0, 1, 0, 1, 0, 0, 3);
    drive(1, 0, 0, 1, 0, 0, 0);
    chk("mid_cnt3", int'(b.cnt_o), 3);
    adv();
    drive(0, 0, 0, 1, 0, 0, 0);
    chk("rst_cnt", int'(b.cnt_o), 0);
    chk("rst_busy", int'(b.busy_o), 0);
    chk("rst_done", int'(b.done_o), 0);
    adv();
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 60) == 0 ? 1 : 0, ($urandom % 3) == 0 ? 1 : 0,
           ($urandom % 25) == 0 ? 1 : 0, ($urandom % 4) != 0 ? 1 : 0,
           int'($urandom % 2), int'($urandom % 2), int'($urandom_range(0, 15)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
